fp_operand_unpack: RTL and testbench
====================================

# fp_operand_unpack

Input-side counterpart of the MAC's result packer: accepts 32-bit IEEE-754 single-precision words, splits them into sign, biased exponent and 24-bit significand with explicit hidden bit, and classifies each operand as zero, denormal, infinity or NaN. Sits between the operand source and the multiplier/adder datapath. A two-stage valid/ready pipeline carries the data, and a saturating counter reports NaN operands for status.

## Interface
- No parameters; widths fixed at single precision (1/8/23).
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  in_word is valid.
- in_word  input  32  packed float {sign, exponent[7:0], fraction[22:0]}.
- in_ready  output  1  block accepts in_word this cycle.
- out_valid  output  1  decoded operand valid.
- out_ready  input  1  downstream accepts decoded operand.
- out_sign  output  1  sign bit.
- out_exponent  output  8  biased exponent, effective value for denormals.
- out_significand  output  24  {hidden bit, fraction}.
- out_is_zero, out_is_denorm, out_is_inf, out_is_nan  output  1 each  class flags; one-hot or all zero for normals.
- nan_count  output  8  saturating count of NaN operands delivered.

## Operation
- Stage 1 (S1) registers the raw word on in_valid && in_ready. Stage 2 (S2) registers the decoded fields and flags.
- S2 loads when S1 is valid and (!S2 valid || out_ready).
- in_ready = !S1_valid || S1 moving into S2 this cycle. This is combinational from out_ready.
- Decode, with e = word[30:23] and f = word[22:0]:
  - e=0, f=0: zero. exponent 0, significand 0.
  - e=0, f≠0: denormal. See Configuration.
  - e=0xFF, f=0: infinity. exponent 0xFF, significand {1'b0, f}.
  - e=0xFF, f≠0: NaN. exponent 0xFF, significand {1'b0, f}. The payload is preserved unchanged.
  - Otherwise normal. exponent e, significand {1'b1, f}, all flags 0.
- out_sign always equals word[31], including for zero and NaN.
- nan_count increments by 1 on each output handshake (out_valid && out_ready) whose out_is_nan = 1. It saturates at 0xFF and never wraps.
- Order is strictly preserved. No drops, no duplication.
- Output fields hold stable while out_valid && !out_ready.

## Timing
- Reset (resetn low, asynchronous): S1_valid, out_valid, every output field, every flag and nan_count go to 0. Once reset is released, in_ready = 1.
- Reset mid-transfer discards any in-flight words. The first word accepted after release appears normally.
- Latency: a word accepted at edge N is presented on out_valid after edge N+1, provided S2 was free.
- Throughput is 1 word/cycle when out_ready is held high.
- Full condition: S1 and S2 both valid with out_ready = 0 gives in_ready = 0.
- Simultaneous accept and drain: with both stages full and out_ready = 1, S2 takes S1, S1 takes the new word, and in_ready = 1 in that cycle.
- The nan_count update is registered; it becomes visible the cycle after the handshake.

## Configuration
- DENORM_FLUSH_EN defined: denormal inputs flush to signed zero. exponent 0, significand 0, out_is_zero = 1, out_is_denorm = 0. out_sign is kept.
- DENORM_FLUSH_EN undefined: denormals are passed gradually. exponent 0x01 (effective), significand {1'b0, f}, out_is_denorm = 1.

## Test plan
- 0x3F800000, out_ready = 1 -> two cycles later: sign 0, exponent 0x7F, significand 0x800000, all flags 0.
- Back-to-back 0xC0490FDB, 0x7F800000 -> in order: (1, 0x80, 0xC90FDB, no flags), then (0, 0xFF, 0x000000, out_is_inf = 1). out_valid stays high for consecutive cycles.
- 0x7FC00001 sent 300 times, out_ready = 1 -> out_is_nan = 1, significand 0x400001 on each. nan_count reads 0xFF at the end, with no wrap.
- 0x80000001 -> without DENORM_FLUSH_EN: sign 1, exponent 0x01, significand 0x000001, out_is_denorm = 1. With DENORM_FLUSH_EN: sign 1, exponent 0, significand 0, out_is_zero = 1.
- out_ready = 0, offer 0x40000000, 0x40400000, 0x40800000 -> first two accepted, in_ready = 0 on the third, out fields stable at exponent 0x80, significand 0x800000. Then out_ready = 1 -> all three emerge in order.
- Assert resetn low with both stages full -> all outputs and nan_count read 0 immediately. After release, in_ready = 1 and the old words are never emitted.

Source files
------------

// File: rtl/fp_operand_unpack_if.sv
// Operand stream interface for fp_operand_unpack: raw float words in, decoded fields out.
// master drives words and downstream ready; slave is the unpacker.
interface fp_operand_unpack_if;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exponent;
    logic [23:0] out_significand;
    logic        out_is_zero;
    logic        out_is_denorm;
    logic        out_is_inf;
    logic        out_is_nan;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_sign, out_exponent, out_significand,
               out_is_zero, out_is_denorm, out_is_inf, out_is_nan
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_sign, out_exponent, out_significand,
               out_is_zero, out_is_denorm, out_is_inf, out_is_nan
    );
endinterface

// File: rtl/fp_operand_unpack.sv
// Two-stage single-precision operand unpacker with class flags and a saturating NaN counter.
// Define DENORM_FLUSH_EN to flush denormal inputs to signed zero instead of passing them gradually.
module fp_operand_unpack (
    input  logic                 clock,
    input  logic                 resetn,
    fp_operand_unpack_if.slave   bus,
    output logic [7:0]           nan_count
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned CNT_W  = 8;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_valid;
    logic [WORD_W-1:0] s1_word;
    logic              s2_load;
    logic              accept;

    logic              s2_valid;
    logic              s2_sign;
    logic [EXP_W-1:0]  s2_exp;
    logic [SIG_W-1:0]  s2_sig;
    logic              s2_zero;
    logic              s2_denorm;
    logic              s2_inf;
    logic              s2_nan;

    logic [EXP_W-1:0]  raw_exp;
    logic [FRAC_W-1:0] raw_frac;
    logic [EXP_W-1:0]  dec_exp;
    logic [SIG_W-1:0]  dec_sig;
    logic              dec_zero;
    logic              dec_denorm;
    logic              dec_inf;
    logic              dec_nan;

    // S1 may refill in the same cycle it hands its word to S2.
    assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_word  <= bus.in_word;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    assign raw_exp  = s1_word[WORD_W-2 -: EXP_W];
    assign raw_frac = s1_word[FRAC_W-1:0];

    // Field decode and classification of the S1 word.
    always_comb begin
        dec_exp    = raw_exp;
        dec_sig    = {1'b1, raw_frac};
        dec_zero   = 1'b0;
        dec_denorm = 1'b0;
        dec_inf    = 1'b0;
        dec_nan    = 1'b0;
        if (raw_exp == '0) begin
            if (raw_frac == '0) begin
                dec_exp  = '0;
                dec_sig  = '0;
                dec_zero = 1'b1;
            end else begin
`ifdef DENORM_FLUSH_EN
                dec_exp  = '0;
                dec_sig  = '0;
                dec_zero = 1'b1;
`else
                dec_exp    = EXP_W'(1);
                dec_sig    = {1'b0, raw_frac};
                dec_denorm = 1'b1;
`endif
            end
        end else if (raw_exp == EXP_MAX) begin
            dec_sig = {1'b0, raw_frac};
            if (raw_frac == '0) begin
                dec_inf = 1'b1;
            end else begin
                dec_nan = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_sig    <= '0;
            s2_zero   <= 1'b0;
            s2_denorm <= 1'b0;
            s2_inf    <= 1'b0;
            s2_nan    <= 1'b0;
        end else if (s2_load) begin
            s2_valid  <= 1'b1;
            s2_sign   <= s1_word[WORD_W-1];
            s2_exp    <= dec_exp;
            s2_sig    <= dec_sig;
            s2_zero   <= dec_zero;
            s2_denorm <= dec_denorm;
            s2_inf    <= dec_inf;
            s2_nan    <= dec_nan;
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Counts delivered NaNs, sticking at all-ones.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            nan_count <= '0;
        end else if (s2_valid && bus.out_ready && s2_nan && (nan_count != CNT_MAX)) begin
            nan_count <= nan_count + CNT_W'(1);
        end
    end

    assign bus.out_valid       = s2_valid;
    assign bus.out_sign        = s2_sign;
    assign bus.out_exponent    = s2_exp;
    assign bus.out_significand = s2_sig;
    assign bus.out_is_zero     = s2_zero;
    assign bus.out_is_denorm   = s2_denorm;
    assign bus.out_is_inf      = s2_inf;
    assign bus.out_is_nan      = s2_nan;
endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed self-checking bench for fp_operand_unpack.
module tb_fp_operand_unpack;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] nan_count;
    int         checks = 0;
    int         errors = 0;

    fp_operand_unpack_if bus ();

    fp_operand_unpack dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus.slave),
        .nan_count (nan_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // flags ordered {zero, denorm, inf, nan}
    task automatic check_out(input string tag, input logic s, input logic [7:0] e,
                             input logic [23:0] sig, input logic [3:0] flags);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sign"},  32'(bus.out_sign), 32'(s));
        chk({tag, "_exp"},   32'(bus.out_exponent), 32'(e));
        chk({tag, "_sig"},   32'(bus.out_significand), 32'(sig));
        chk({tag, "_flags"}, 32'({bus.out_is_zero, bus.out_is_denorm, bus.out_is_inf, bus.out_is_nan}),
            32'(flags));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fields", 32'({bus.out_sign, bus.out_exponent, bus.out_significand}), 32'd0);
        chk("rst_flags", 32'({bus.out_is_zero, bus.out_is_denorm, bus.out_is_inf, bus.out_is_nan}), 32'd0);
        chk("rst_nan_count", 32'(nan_count), 32'd0);
        resetn = 1'b1;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 1.0
        bus.in_valid = 1'b1;
        bus.in_word  = 32'h3F800000;
        tick();
        bus.in_valid = 1'b0;
        check_idle("one_lat");
        tick();
        check_out("one", 1'b0, 8'h7F, 24'h800000, 4'b0000);
        tick();
        check_idle("one_after");

        // Back-to-back pi and +inf
        bus.in_valid = 1'b1;
        bus.in_word  = 32'hC0490FDB;
        tick();
        bus.in_word  = 32'h7F800000;
        tick();
        bus.in_valid = 1'b0;
        check_out("pi", 1'b1, 8'h80, 24'hC90FDB, 4'b0000);
        tick();
        check_out("inf", 1'b0, 8'hFF, 24'h000000, 4'b0010);
        tick();
        check_idle("inf_after");
        chk("nan_count_inf", 32'(nan_count), 32'd0);

        // Smallest negative denormal
        bus.in_valid = 1'b1;
        bus.in_word  = 32'h80000001;
        tick();
        bus.in_valid = 1'b0;
        tick();
`ifdef DENORM_FLUSH_EN
        check_out("denorm", 1'b1, 8'h00, 24'h000000, 4'b1000);
`else
        check_out("denorm", 1'b1, 8'h01, 24'h000001, 4'b0100);
`endif
        tick();

        // Backpressure: two accepted, third blocked
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h40000000;
        chk("bp_ready0", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_word = 32'h40400000;
        chk("bp_ready1", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_word = 32'h40800000;
        chk("bp_full", 32'(bus.in_ready), 32'd0);
        check_out("bp_hold0", 1'b0, 8'h80, 24'h800000, 4'b0000);
        tick();
        chk("bp_full2", 32'(bus.in_ready), 32'd0);
        check_out("bp_hold1", 1'b0, 8'h80, 24'h800000, 4'b0000);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_drain_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_out("bp_w1", 1'b0, 8'h80, 24'hC00000, 4'b0000);
        tick();
        check_out("bp_w2", 1'b0, 8'h81, 24'h800000, 4'b0000);
        tick();
        check_idle("bp_after");

        // NaN stream, 300 words
        bus.in_valid = 1'b1;
        bus.in_word  = 32'h7FC00001;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 1) begin
                check_out("nan_first", 1'b0, 8'hFF, 24'h400001, 4'b0001);
            end
            if (i >= 1) begin
                chk("nan_flag", 32'(bus.out_is_nan), 32'd1);
                chk("nan_sig", 32'(bus.out_significand), 32'h400001);
                chk("nan_valid", 32'(bus.out_valid), 32'd1);
            end
            if (i == 100) begin
                chk("nan_count_mid", 32'(nan_count), 32'd99);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check_idle("nan_after");
        chk("nan_count_sat", 32'(nan_count), 32'hFF);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h3F800000;
        tick();
        bus.in_word = 32'h40000000;
        tick();
        bus.in_valid = 1'b0;
        chk("full_before_rst", 32'(bus.in_ready), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_fields", 32'({bus.out_sign, bus.out_exponent, bus.out_significand}), 32'd0);
        chk("mrst_flags", 32'({bus.out_is_zero, bus.out_is_denorm, bus.out_is_inf, bus.out_is_nan}), 32'd0);
        chk("mrst_nan_count", 32'(nan_count), 32'd0);
        tick();
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_idle("mrst_no_old0");
        tick();
        check_idle("mrst_no_old1");
        bus.in_valid = 1'b1;
        bus.in_word  = 32'h40400000;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_out("mrst_new", 1'b0, 8'h80, 24'hC00000, 4'b0000);
        tick();
        check_idle("mrst_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
